// File: rtl/line_buffer_ctrl.sv
// Frame sequencer for the 3x3 line buffer. It clears the buffer before each frame,
// then forwards a raster pixel stream with its coordinates and flags complete windows.
module line_buffer_ctrl #(
    parameter int DATA_W       = 8,
    parameter int XW           = 11,
    parameter int YW           = 10,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        img_width,
    input  logic [YW-1:0]     img_height,
    input  logic [DATA_W-1:0] s_pixel,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] lb_pixel,
    output logic              lb_valid,
    output logic              lb_clear,
    output logic [XW-1:0]     lb_x,
    output logic [YW-1:0]     lb_y,
    output logic              win_valid,
    output logic              busy,
    output logic              frame_done,
    output logic              cfg_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CLEAR  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    logic [1:0]        r_state;
    logic [7:0]        r_w_l;
    logic [YW-1:0]     r_h_l;
    logic [XW-1:0]     r_col;
    logic [YW-1:0]     r_row;
    logic [CW-1:0]     r_clr_cnt;
    logic [DATA_W-1:0] r_lb_pixel;
    logic [XW-1:0]     r_lb_x;
    logic [YW-1:0]     r_lb_y;
    logic              r_lb_valid;
    logic              r_win_valid;
    logic              r_frame_done;
    logic              r_cfg_err;

    logic              w_cfg_ok;
    logic              w_accept;
    logic [XW-1:0]     w_col_max;
    logic              w_col_last;
    logic              w_row_last;

    assign w_cfg_ok   = (img_width >= 8'd3) && (img_height >= YW'(3));
    assign w_accept   = s_valid && s_ready;
    // Width is 8 bits wide; zero-extend before the subtraction so the compare is XW bits.
    assign w_col_max  = {{(XW-8){1'b0}}, r_w_l} - XW'(1);
    assign w_col_last = (r_col == w_col_max);
    assign w_row_last = (r_row == (r_h_l - YW'(1)));

    assign s_ready    = (r_state == S_STREAM);
    assign lb_clear   = (r_state == S_CLEAR);
    assign busy       = (r_state == S_CLEAR) || (r_state == S_STREAM);
    assign lb_pixel   = r_lb_pixel;
    assign lb_x       = r_lb_x;
    assign lb_y       = r_lb_y;
    assign lb_valid   = r_lb_valid;
    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;
    assign cfg_err    = r_cfg_err;

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order within the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_w_l        <= '0;
            r_h_l        <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_clr_cnt    <= '0;
            r_lb_pixel   <= '0;
            r_lb_x       <= '0;
            r_lb_y       <= '0;
            r_lb_valid   <= 1'b0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_lb_valid   <= 1'b0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_cfg_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            r_w_l     <= img_width;
                            r_h_l     <= img_height;
                            r_col     <= '0;
                            r_row     <= '0;
                            r_clr_cnt <= '0;
                            r_state   <= S_CLEAR;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    if (r_clr_cnt == CW'(CLEAR_CYCLES - 1)) begin
                        r_state <= S_STREAM;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + CW'(1);
                    end
                end
                S_STREAM: begin
                    if (w_accept) begin
                        r_lb_pixel  <= s_pixel;
                        r_lb_x      <= r_col;
                        r_lb_y      <= r_row;
                        r_lb_valid  <= 1'b1;
                        r_win_valid <= (r_col >= XW'(2)) && (r_row >= YW'(2));
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) begin
                                r_row        <= '0;
                                r_frame_done <= 1'b1;
                                r_state      <= S_IDLE;
                            end else begin
                                r_row <= r_row + YW'(1);
                            end
                        end else begin
                            r_col <= r_col + XW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl: clear timing, streaming coordinates and windows,
// backpressure, configuration errors, mid-frame reset, ignored and back-to-back starts.
module tb_line_buffer_ctrl;

    localparam int DATA_W       = 8;
    localparam int XW           = 11;
    localparam int YW           = 10;
    localparam int CLEAR_CYCLES = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        img_width;
    logic [YW-1:0]     img_height;
    logic [DATA_W-1:0] s_pixel;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] lb_pixel;
    logic              lb_valid;
    logic              lb_clear;
    logic [XW-1:0]     lb_x;
    logic [YW-1:0]     lb_y;
    logic              win_valid;
    logic              busy;
    logic              frame_done;
    logic              cfg_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    line_buffer_ctrl #(
        .DATA_W(DATA_W), .XW(XW), .YW(YW), .CLEAR_CYCLES(CLEAR_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .img_width(img_width), .img_height(img_height),
        .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
        .lb_pixel(lb_pixel), .lb_valid(lb_valid), .lb_clear(lb_clear),
        .lb_x(lb_x), .lb_y(lb_y), .win_valid(win_valid),
        .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge that produced them.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"},    32'(s_ready),    0);
        check({tag, "_lb_pixel"},   32'(lb_pixel),   0);
        check({tag, "_lb_valid"},   32'(lb_valid),   0);
        check({tag, "_lb_clear"},   32'(lb_clear),   0);
        check({tag, "_lb_x"},       32'(lb_x),       0);
        check({tag, "_lb_y"},       32'(lb_y),       0);
        check({tag, "_win_valid"},  32'(win_valid),  0);
        check({tag, "_busy"},       32'(busy),       0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
        check({tag, "_cfg_err"},    32'(cfg_err),    0);
    endtask

    task automatic start_frame(input int w, input int h);
        start      = 1'b1;
        img_width  = 8'(w);
        img_height = YW'(h);
        tick();
        start = 1'b0;
        for (int c = 0; c < CLEAR_CYCLES; c++) begin
            check("clear_lb_clear", 32'(lb_clear), 1);
            check("clear_busy",     32'(busy),     1);
            check("clear_s_ready",  32'(s_ready),  0);
            tick();
        end
        check("first_s_ready",  32'(s_ready),  1);
        check("first_lb_clear", 32'(lb_clear), 0);
    endtask

    // Streams pixels 1..stop; start_at >= 0 raises start while that pixel index is offered.
    task automatic stream(input int w, input int h, input bit bp, input int stop, input int start_at);
        int total = w * h;
        int sent  = 0;
        int wins  = 0;
        int dones = 0;
        int cyc   = 0;
        bit acc;
        while (sent < stop && cyc < 400) begin
            s_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            s_pixel = DATA_W'(sent + 1);
            start   = (sent == start_at);
            check("s_ready", 32'(s_ready), 1);
            acc = s_valid;
            tick();
            cyc++;
            if (acc) begin
                check("lb_valid",   32'(lb_valid),   1);
                check("lb_pixel",   32'(lb_pixel),   sent + 1);
                check("lb_x",       32'(lb_x),       sent % w);
                check("lb_y",       32'(lb_y),       sent / w);
                check("win_valid",  32'(win_valid),  32'((sent % w) >= 2 && (sent / w) >= 2));
                check("frame_done", 32'(frame_done), 32'(sent == total - 1));
                wins  += int'(win_valid);
                dones += int'(frame_done);
                sent++;
            end else begin
                check("gap_lb_valid",   32'(lb_valid),   0);
                check("gap_win_valid",  32'(win_valid),  0);
                check("gap_frame_done", 32'(frame_done), 0);
                if (sent > 0) check("gap_hold_pixel", 32'(lb_pixel), sent);
            end
        end
        s_valid = 1'b0;
        start   = 1'b0;
        check("accept_count", sent, stop);
        if (stop == total) begin
            check("win_count",     wins,          (w - 2) * (h - 2));
            check("done_count",    dones,         1);
            check("end_busy",      32'(busy),     0);
            check("end_s_ready",   32'(s_ready),  0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        img_width  = '0;
        img_height = '0;
        s_pixel    = '0;
        s_valid    = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Basic 8x4 frame, s_valid held high.
        start_frame(8, 4);
        stream(8, 4, 1'b0, 32, -1);
        tick();
        check("post_frame_done", 32'(frame_done), 0);

        // Same frame under random backpressure.
        start_frame(8, 4);
        stream(8, 4, 1'b1, 32, -1);
        tick();

        // Bad width, then bad height: one cfg_err each, never busy.
        start = 1'b1; img_width = 8'd2; img_height = YW'(4);
        tick();
        start = 1'b0;
        check("cfg_w_err",      32'(cfg_err),  1);
        check("cfg_w_busy",     32'(busy),     0);
        check("cfg_w_lb_clear", 32'(lb_clear), 0);
        check("cfg_w_s_ready",  32'(s_ready),  0);
        tick();
        check("cfg_w_pulse",    32'(cfg_err),  0);
        check("cfg_w_busy2",    32'(busy),     0);
        start = 1'b1; img_width = 8'd8; img_height = YW'(2);
        tick();
        start = 1'b0;
        check("cfg_h_err",      32'(cfg_err),  1);
        check("cfg_h_busy",     32'(busy),     0);
        check("cfg_h_lb_clear", 32'(lb_clear), 0);
        check("cfg_h_s_ready",  32'(s_ready),  0);
        tick();
        check("cfg_h_pulse",    32'(cfg_err),  0);
        check("cfg_h_busy2",    32'(busy),     0);

        // Reset after 10 accepts, then a clean frame.
        start_frame(8, 4);
        stream(8, 4, 1'b0, 10, -1);
        reset = 1'b1;
        tick();
        check_all_zero("midreset");
        reset = 1'b0;
        start_frame(8, 4);
        stream(8, 4, 1'b0, 32, -1);
        tick();

        // Mid-frame start with changed img_* is ignored; then start in the frame_done cycle.
        start_frame(8, 4);
        img_width  = 8'd5;
        img_height = YW'(3);
        stream(8, 4, 1'b0, 32, 5);
        start_frame(5, 3);
        stream(5, 3, 1'b0, 15, -1);
        tick();

        // Minimum 3x3 frame: one window, coincident with frame_done.
        start_frame(3, 3);
        stream(3, 3, 1'b0, 9, -1);
        check("min_lb_x", 32'(lb_x), 2);
        check("min_lb_y", 32'(lb_y), 2);
        tick();
        check("idle_win_valid", 32'(win_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Frame sequencer for the 3x3 line buffer in the CNN front end. It takes a raster pixel stream over a valid/ready handshake and a per-frame configuration (width, height). It clears the line buffer before each frame and drives the buffer's pixel, valid and coordinate inputs. It also flags the cycles on which a complete 3x3 window is available for the convolution stage and reports frame completion.

## Interface
- DATA_W, 8, pixel width
- XW, 11, column coordinate width
- YW, 10, row coordinate width
- CLEAR_CYCLES, 2, cycles `lb_clear` is held before each frame (>=1)

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous reset, active-high
- start  in  1  frame start request; honoured only in IDLE
- img_width  in  8  pixels per row; sampled on accepted start
- img_height  in  YW  rows per frame; sampled on accepted start
- s_pixel  in  DATA_W  input pixel
- s_valid  in  1  input pixel valid
- s_ready  out  1  controller accepts a pixel this cycle
- lb_pixel  out  DATA_W  pixel to the line buffer
- lb_valid  out  1  `lb_pixel` / `lb_x` / `lb_y` valid this cycle
- lb_clear  out  1  line buffer clear
- lb_x  out  XW  column of `lb_pixel`
- lb_y  out  YW  row of `lb_pixel`
- win_valid  out  1  with `lb_valid`: a full 3x3 window ends at this pixel
- busy  out  1  frame in progress (CLEAR or STREAM)
- frame_done  out  1  one-cycle pulse on the last pixel of a frame
- cfg_err  out  1  one-cycle pulse: start rejected for bad configuration

## Operation
- States: IDLE, CLEAR, STREAM. Reset forces IDLE.
- IDLE, start=1, img_width>=3 and img_height>=3:
  - Latch the width and height into `w_l` and `h_l`.
  - Zero the column counter `col`, the row counter `row` and the clear counter.
  - Go to CLEAR.
- IDLE, start=1, bad configuration: pulse `cfg_err` next cycle; stay in IDLE.
- CLEAR:
  - `lb_clear`=1 (decoded from the state register).
  - Stay for exactly CLEAR_CYCLES cycles, then go to STREAM.
- STREAM:
  - `s_ready`=1 (decoded from state).
  - Accept a pixel when `s_valid && s_ready`.
  - On accept, register `lb_pixel`=s_pixel, `lb_x`=col, `lb_y`=row and `lb_valid`=1.
  - On accept, register `win_valid`=(col>=2 && row>=2).
  - `col` advances by 1. When col==w_l-1, `col` returns to 0 and `row` advances by 1.
  - Compare `col` zero-extended against {3'b0, w_l}-1. Counters never exceed w_l-1 and h_l-1.
  - Accepting the last pixel (col==w_l-1 and row==h_l-1) registers `frame_done`=1 alongside that pixel's `lb_valid` and moves the state to IDLE.
- No accept in a cycle: `lb_valid`, `win_valid` and `frame_done` are 0 the next cycle. `lb_pixel`, `lb_x` and `lb_y` hold their values.
- start outside IDLE is ignored. Latched config is unaffected by `img_*` changes mid-frame.
- `busy` = state is CLEAR or STREAM.
- Reset mid-frame: the next edge returns every output to its reset value and discards the partial frame. The next start begins a clean frame, including the clear phase.

## Timing
- Reset values:
  - 0: `s_ready`, `lb_pixel`, `lb_valid`, `lb_clear`, `lb_x`, `lb_y`, `win_valid`, `busy`, `frame_done`, `cfg_err`.
  - Internally: state IDLE, counters 0.
- start seen at edge N: `lb_clear` and `busy` are high for cycles N+1 .. N+CLEAR_CYCLES.
- `s_ready` first high in cycle N+CLEAR_CYCLES+1.
- Accept at edge M: the pixel appears on the `lb_*` outputs in cycle M+1. Latency is fixed at 1.
- Throughput: 1 pixel/cycle with `s_valid` held high. No bubbles at row wrap.
- Last accept at edge L: `frame_done` and the final `lb_valid` are high in cycle L+1.
- At edge L, `s_ready` and `busy` drop, so no pixel is accepted past the frame end.
- Earliest next start is the start sampled in cycle L+1, giving `lb_clear` from L+2.
- Minimum frame: 3x3, which produces exactly one `win_valid`.

## Test plan
- Basic frame:
  - Stimulus: width 8, height 4, CLEAR_CYCLES=2, `s_valid` held high, `s_pixel`=1..32.
  - Response: `lb_clear` high for 2 cycles. 32 consecutive `lb_valid` with pixel i+1, x=i%8, y=i/8.
  - Response: `win_valid` 12 times, first at (2,2). `frame_done` exactly once, with pixel 32.
- Backpressure:
  - Stimulus: same frame, `s_valid` toggled pseudo-randomly.
  - Response: identical `lb_*` sequence with gaps, no duplicated or lost pixels, `frame_done` once.
- Config error:
  - Stimulus: start with width 2, then start with height 2.
  - Response: one `cfg_err` pulse each. `busy`, `lb_clear` and `s_ready` stay 0.
- Reset mid-frame:
  - Stimulus: assert reset after 10 accepts, then start a fresh 8x4 frame.
  - Response: all outputs 0 the cycle after reset. The second frame matches the basic frame exactly.
- Ignored start and back-to-back:
  - Stimulus: pulse start during STREAM; then assert start in the `frame_done` cycle.
  - Response: the mid-frame start has no effect. The second start begins a new clear 1 cycle after `frame_done`, using the newly latched width.
- Minimum frame:
  - Stimulus: 3x3 frame.
  - Response: 9 `lb_valid`, a single `win_valid` on (2,2) coincident with `frame_done`.
